// File: rtl/dmx_pkg.sv
// Shared widths, types and constants for the DMX512 channel-value path.
package dmx_pkg;

  localparam int unsigned DMX_ADDR_W = 9;
  localparam int unsigned DMX_DATA_W = 8;

  typedef logic [DMX_ADDR_W-1:0] dmx_addr_t;
  typedef logic [DMX_DATA_W-1:0] dmx_data_t;

  localparam dmx_data_t DMX_START_CODE = 8'h00;

endpackage

// File: rtl/dmx_channel_lookup.sv
// Combinational priority decode of a DMX slot number into its channel value.
module dmx_channel_lookup
  import dmx_pkg::*;
#(
  parameter dmx_addr_t DIMMER_ADDR = 9'd2,
  parameter dmx_data_t DIMMER_VAL  = 8'd255
) (
  input  logic [DMX_ADDR_W-1:0] addr,
  input  logic [DMX_ADDR_W-1:0] pan_addr,
  input  logic [DMX_ADDR_W-1:0] tilt_addr,
  input  logic [DMX_DATA_W-1:0] pan,
  input  logic [DMX_DATA_W-1:0] tilt,
  output logic [DMX_DATA_W-1:0] data
);

  // Slot 0 is always the start code, even if a channel register points there.
  always_comb begin
    data = '0;
    if (addr == '0) begin
      data = DMX_START_CODE;
    end else if (addr == pan_addr) begin
      data = pan;
    end else if (addr == tilt_addr) begin
      data = tilt;
    end else if (addr == DIMMER_ADDR) begin
      data = DIMMER_VAL;
    end
  end

endmodule

// File: rtl/dmx_processor.sv
// Holds the latest pan/tilt result and answers DMX writer slot reads with a
// registered address/data pair.
module dmx_processor
  import dmx_pkg::*;
#(
  parameter dmx_addr_t PAN_ADDR_RST  = 9'd1,
  parameter dmx_addr_t TILT_ADDR_RST = 9'd3,
  parameter dmx_data_t PAN_RST       = 8'd128,
  parameter dmx_data_t TILT_RST      = 8'd128,
  parameter dmx_addr_t DIMMER_ADDR   = 9'd2,
  parameter dmx_data_t DIMMER_VAL    = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] pan_addr,
  input  logic [8:0] tilt_addr,
  input  logic [7:0] pan,
  input  logic [7:0] tilt,
  input  logic       calc_ready,
  input  logic [8:0] request_addr,
  input  logic       request_pulse,
  output logic [8:0] addr_out,
  output logic [7:0] data_out
);

  dmx_addr_t pan_addr_q, pan_addr_d;
  dmx_addr_t tilt_addr_q, tilt_addr_d;
  dmx_data_t pan_q, pan_d;
  dmx_data_t tilt_q, tilt_d;
  dmx_addr_t addr_out_q, addr_out_d;
  dmx_data_t data_out_q, data_out_d;
  dmx_data_t lookup_data;

  // Decode runs on the registered table, so a same-cycle update is not seen.
  dmx_channel_lookup #(
    .DIMMER_ADDR (DIMMER_ADDR),
    .DIMMER_VAL  (DIMMER_VAL)
  ) u_lookup (
    .addr      (request_addr),
    .pan_addr  (pan_addr_q),
    .tilt_addr (tilt_addr_q),
    .pan       (pan_q),
    .tilt      (tilt_q),
    .data      (lookup_data)
  );

  always_comb begin
    pan_addr_d  = pan_addr_q;
    tilt_addr_d = tilt_addr_q;
    pan_d       = pan_q;
    tilt_d      = tilt_q;
    addr_out_d  = addr_out_q;
    data_out_d  = data_out_q;
    if (calc_ready) begin
      pan_addr_d  = pan_addr;
      tilt_addr_d = tilt_addr;
      pan_d       = pan;
      tilt_d      = tilt;
    end
    if (request_pulse) begin
      addr_out_d = request_addr;
      data_out_d = lookup_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pan_addr_q  <= PAN_ADDR_RST;
      tilt_addr_q <= TILT_ADDR_RST;
      pan_q       <= PAN_RST;
      tilt_q      <= TILT_RST;
      addr_out_q  <= '0;
      data_out_q  <= '0;
    end else begin
      pan_addr_q  <= pan_addr_d;
      tilt_addr_q <= tilt_addr_d;
      pan_q       <= pan_d;
      tilt_q      <= tilt_d;
      addr_out_q  <= addr_out_d;
      data_out_q  <= data_out_d;
    end
  end

  assign addr_out = addr_out_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_dmx_processor.sv
// Scoreboard bench for dmx_processor: expected slot reads queued at drive time.
module tb_dmx_processor;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] pan_addr, tilt_addr, request_addr;
  logic [7:0] pan, tilt;
  logic       calc_ready, request_pulse;
  logic [8:0] addr_out;
  logic [7:0] data_out;

  typedef struct {
    logic [8:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int unsigned assert_cnt = 0;
  int unsigned fail_cnt = 0;

  // Independent reference of the channel table.
  logic [8:0] m_pan_addr, m_tilt_addr;
  logic [7:0] m_pan, m_tilt;

  always #5 clk = ~clk;

  dmx_processor #(
    .PAN_ADDR_RST  (9'd1),
    .TILT_ADDR_RST (9'd3),
    .PAN_RST       (8'd128),
    .TILT_RST      (8'd128),
    .DIMMER_ADDR   (9'd2),
    .DIMMER_VAL    (8'd255)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pan_addr      (pan_addr),
    .tilt_addr     (tilt_addr),
    .pan           (pan),
    .tilt          (tilt),
    .calc_ready    (calc_ready),
    .request_addr  (request_addr),
    .request_pulse (request_pulse),
    .addr_out      (addr_out),
    .data_out      (data_out)
  );

  function automatic logic [7:0] ref_lookup(input logic [8:0] a);
    if (a == 9'd0) return 8'h00;
    if (a == m_pan_addr) return m_pan;
    if (a == m_tilt_addr) return m_tilt;
    if (a == 9'd2) return 8'd255;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_pan_addr  = 9'd1;
    m_tilt_addr = 9'd3;
    m_pan       = 8'd128;
    m_tilt      = 8'd128;
  endtask

  task automatic send_req(input logic [8:0] a);
    @(negedge clk);
    request_addr  = a;
    request_pulse = 1'b1;
    @(negedge clk);
    request_pulse = 1'b0;
  endtask

  task automatic do_calc(input logic [8:0] pa, input logic [8:0] ta,
                         input logic [7:0] p, input logic [7:0] t);
    @(negedge clk);
    pan_addr   = pa;
    tilt_addr  = ta;
    pan        = p;
    tilt       = t;
    calc_ready = 1'b1;
    @(negedge clk);
    calc_ready = 1'b0;
    m_pan_addr  = pa;
    m_tilt_addr = ta;
    m_pan       = p;
    m_tilt      = t;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pan_addr = '0; tilt_addr = '0; pan = '0; tilt = '0;
    calc_ready = 1'b0; request_addr = '0; request_pulse = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    assert_cnt++;
    if (addr_out !== 9'd0 || data_out !== 8'd0) begin
      fail_cnt++;
      $display("FAIL reset_state: got %0d/%0d, expected 0/0", addr_out, data_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_table();
    logic [8:0] addrs [5] = '{9'd2, 9'd1, 9'd3, 9'd7, 9'd511};
    logic [7:0] datas [5] = '{8'd255, 8'd128, 8'd128, 8'd0, 8'd0};
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{addrs[i], datas[i]});
      send_req(addrs[i]);
      e = sb.pop_front();
      assert_cnt++;
      if (addr_out !== e.a || data_out !== e.d) begin
        fail_cnt++;
        $display("FAIL reset_table[%0d]: got %0d/%0d, expected %0d/%0d",
                 i, addr_out, data_out, e.a, e.d);
      end
    end
  endtask

  task automatic test_calc_update();
    logic [8:0] addrs [5] = '{9'd10, 9'd11, 9'd1, 9'd3, 9'd2};
    logic [7:0] datas [5] = '{8'h40, 8'hC0, 8'h00, 8'h00, 8'd255};
    do_calc(9'd10, 9'd11, 8'h40, 8'hC0);
    // calc_ready alone must leave the outputs on the last read (511 -> 0).
    assert_cnt++;
    if (addr_out !== 9'd511 || data_out !== 8'd0) begin
      fail_cnt++;
      $display("FAIL calc_no_output_change: got %0d/%0d, expected 511/0", addr_out, data_out);
    end
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{addrs[i], datas[i]});
      send_req(addrs[i]);
      e = sb.pop_front();
      assert_cnt++;
      if (addr_out !== e.a || data_out !== e.d) begin
        fail_cnt++;
        $display("FAIL calc_update[%0d]: got %0d/%0h, expected %0d/%0h",
                 i, addr_out, data_out, e.a, e.d);
      end
    end
  endtask

  task automatic test_start_code();
    do_calc(9'd0, 9'd0, 8'hAA, 8'hBB);
    sb.push_back('{9'd0, 8'h00});
    send_req(9'd0);
    e = sb.pop_front();
    assert_cnt++;
    if (addr_out !== e.a || data_out !== e.d) begin
      fail_cnt++;
      $display("FAIL start_code: got %0d/%0h, expected %0d/%0h", addr_out, data_out, e.a, e.d);
    end
  endtask

  task automatic test_pan_priority();
    do_calc(9'd5, 9'd5, 8'h11, 8'h22);
    sb.push_back('{9'd5, 8'h11});
    send_req(9'd5);
    e = sb.pop_front();
    assert_cnt++;
    if (addr_out !== e.a || data_out !== e.d) begin
      fail_cnt++;
      $display("FAIL pan_priority: got %0d/%0h, expected %0d/%0h", addr_out, data_out, e.a, e.d);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    assert_cnt++;
    if (addr_out !== 9'd0 || data_out !== 8'd0) begin
      fail_cnt++;
      $display("FAIL async_reset: got %0d/%0h, expected 0/0", addr_out, data_out);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    sb.push_back('{9'd1, 8'd128});
    send_req(9'd1);
    e = sb.pop_front();
    assert_cnt++;
    if (addr_out !== e.a || data_out !== e.d) begin
      fail_cnt++;
      $display("FAIL post_reset_read: got %0d/%0d, expected %0d/%0d", addr_out, data_out, e.a, e.d);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    pan_addr = 9'd1; tilt_addr = 9'd3; pan = 8'h55; tilt = 8'd128;
    calc_ready = 1'b1;
    request_addr = 9'd1;
    request_pulse = 1'b1;
    sb.push_back('{9'd1, ref_lookup(9'd1)});
    m_pan = 8'h55;
    @(negedge clk);
    calc_ready = 1'b0;
    request_pulse = 1'b0;
    e = sb.pop_front();
    assert_cnt++;
    if (addr_out !== e.a || data_out !== e.d || e.d !== 8'd128) begin
      fail_cnt++;
      $display("FAIL same_cycle_old: got %0d/%0h, expected %0d/%0h", addr_out, data_out, e.a, e.d);
    end
    sb.push_back('{9'd1, 8'h55});
    send_req(9'd1);
    e = sb.pop_front();
    assert_cnt++;
    if (addr_out !== e.a || data_out !== e.d) begin
      fail_cnt++;
      $display("FAIL same_cycle_new: got %0d/%0h, expected %0d/%0h", addr_out, data_out, e.a, e.d);
    end
  endtask

  task automatic test_held_pulse();
    // Pulse held for 4 cycles on one address; pan changes in the second cycle.
    @(negedge clk);
    request_addr = 9'd1;
    request_pulse = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{9'd1, ref_lookup(9'd1)});
      if (i == 1) begin
        pan_addr = 9'd1; tilt_addr = 9'd3; pan = 8'h77; tilt = 8'd128;
        calc_ready = 1'b1;
        m_pan = 8'h77;
      end
      @(negedge clk);
      calc_ready = 1'b0;
      if (i == 3) request_pulse = 1'b0;
      e = sb.pop_front();
      assert_cnt++;
      if (addr_out !== e.a || data_out !== e.d) begin
        fail_cnt++;
        $display("FAIL held_pulse[%0d]: got %0d/%0h, expected %0d/%0h",
                 i, addr_out, data_out, e.a, e.d);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] pool [8] = '{9'd0, 9'd1, 9'd2, 9'd3, 9'd20, 9'd21, 9'd511, 9'd100};
    logic [8:0] a;
    do_calc(9'd20, 9'd21, 8'h3C, 8'hC3);
    @(negedge clk);
    a = pool[$urandom_range(0, 7)];
    request_addr = a;
    request_pulse = 1'b1;
    sb.push_back('{a, ref_lookup(a)});
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      assert_cnt++;
      if (addr_out !== e.a || data_out !== e.d) begin
        fail_cnt++;
        $display("FAIL back_to_back[%0d]: got %0d/%0h, expected %0d/%0h",
                 i, addr_out, data_out, e.a, e.d);
      end
      if (i < 15) begin
        a = (i % 5 == 4) ? 9'($urandom_range(0, 511)) : pool[$urandom_range(0, 7)];
        request_addr = a;
        sb.push_back('{a, ref_lookup(a)});
      end else begin
        request_pulse = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_table();
    test_calc_update();
    test_start_code();
    test_pan_priority();
    test_reset_midop();
    test_same_cycle();
    test_held_pulse();
    test_back_to_back();
    assert_cnt++;
    if (sb.size() != 0) begin
      fail_cnt++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
